// File: rtl/interrupt_controller.sv
// Prioritising interrupt/exception arbiter feeding the trap logic of csr_controller.
// Lowest-index enabled request wins; tracks the active handler and acknowledges the device on mret.
module interrupt_controller #(
    parameter int          IRQ_NUM    = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [IRQ_NUM-1:0] irq_ret_o,
    output logic               busy_o
);

    localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] IRQ_SVC    = 2'd1;
    localparam logic [1:0] EXC_SVC    = 2'd2;
    localparam logic [1:0] EXC_IN_IRQ = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, sel;
    logic [IRQ_NUM-1:0] pend;
    logic               take, ack;

    assign pend = irq_req_i & mie_i;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        sel = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    // Gating with rst_i keeps the combinational outputs quiet during reset.
    assign take = (state_q == IDLE) & ~exception_i & (|pend) & ~rst_i;
    assign ack  = (state_q == IRQ_SVC) & mret_i & ~exception_i & ~rst_i;

    assign irq_o       = take;
    assign irq_cause_o = take ? (CAUSE_BASE + {{(32-IDX_W){1'b0}}, sel}) : 32'd0;
    assign irq_ret_o   = ack ? (IRQ_NUM'(1) << idx_q) : '0;
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (exception_i) begin
            case (state_q)
                IDLE:    state_d = EXC_SVC;
                IRQ_SVC: state_d = EXC_IN_IRQ;
                default: state_d = state_q;
            endcase
        end else if (take) begin
            state_d = IRQ_SVC;
            idx_d   = sel;
        end else if (mret_i) begin
            case (state_q)
                IRQ_SVC:    state_d = IDLE;
                EXC_SVC:    state_d = IDLE;
                EXC_IN_IRQ: state_d = IRQ_SVC;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a randomized stream
// compared against a handler-flag model of the arbiter.
module tb_interrupt_controller;

    localparam int          N  = 16;
    localparam logic [31:0] CB = 32'h8000_0010;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         exception_i = 1'b0;
    logic         mret_i = 1'b0;
    logic [N-1:0] mie_i = '0;
    logic [N-1:0] irq_req_i = '0;
    logic         irq_o;
    logic [31:0]  irq_cause_o;
    logic [N-1:0] irq_ret_o;
    logic         busy_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which handlers are live, plus the serviced line.
    bit m_in_irq = 0;
    bit m_in_exc = 0;
    int m_idx = 0;

    interrupt_controller #(.IRQ_NUM(N), .CAUSE_BASE(CB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .exception_i(exception_i), .mret_i(mret_i),
        .mie_i(mie_i), .irq_req_i(irq_req_i), .irq_o(irq_o), .irq_cause_o(irq_cause_o),
        .irq_ret_o(irq_ret_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_in_irq = 0;
        m_in_exc = 0;
        m_idx    = 0;
    endtask

    task automatic model_step();
        int s;
        s = lowest(irq_req_i & mie_i);
        if (rst_i) model_reset();
        else if (exception_i) m_in_exc = 1;
        else if (!m_in_irq && !m_in_exc && s >= 0) begin
            m_in_irq = 1;
            m_idx    = s;
        end else if (mret_i) begin
            if (m_in_exc) m_in_exc = 0;
            else if (m_in_irq) m_in_irq = 0;
        end
    endtask

    task automatic model_outputs(output logic e_irq, output logic [31:0] e_cause,
                                 output logic [N-1:0] e_ret, output logic e_busy);
        int  s;
        bit  idle;
        s      = lowest(irq_req_i & mie_i);
        idle   = !m_in_irq && !m_in_exc;
        e_irq  = !rst_i && idle && !exception_i && (s >= 0);
        e_cause = e_irq ? CB + 32'(s) : 32'd0;
        e_ret  = (!rst_i && m_in_irq && !m_in_exc && mret_i && !exception_i) ? (N'(1) << m_idx) : '0;
        e_busy = !rst_i && !idle;
    endtask

    // Called at posedge+1; settles inputs and leaves time at posedge+3 for sampling.
    task automatic drive(input logic exc, input logic mret, input logic [N-1:0] mie, input logic [N-1:0] req);
        exception_i = exc;
        mret_i      = mret;
        mie_i       = mie;
        irq_req_i   = req;
        #2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, '1, '1);
        n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_irq: got %b want 0", irq_o); end
        n_cmp++; if (irq_cause_o !== 32'd0) begin n_err++; $display("[TB] FAIL rst_cause: got %h want 0", irq_cause_o); end
        n_cmp++; if (irq_ret_o !== '0) begin n_err++; $display("[TB] FAIL rst_ret: got %h want 0", irq_ret_o); end
        tick();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b want 0", busy_o); end
        drive(1'b0, 1'b0, '0, '0);
        rst_i = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_single();
        drive(1'b0, 1'b0, 16'h0008, 16'h0008);
        n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("[TB] FAIL t1_irq: got %b want 1", irq_o); end
        n_cmp++; if (irq_cause_o !== 32'h8000_0013) begin n_err++; $display("[TB] FAIL t1_cause: got %h want 80000013", irq_cause_o); end
        tick();
        drive(1'b0, 1'b0, 16'h0008, 16'h0008);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("[TB] FAIL t1_busy: got %b want 1", busy_o); end
        n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("[TB] FAIL t1_no_nest: got %b want 0", irq_o); end
        drive(1'b0, 1'b1, 16'h0008, 16'h0008);
        n_cmp++; if (irq_ret_o !== 16'h0008) begin n_err++; $display("[TB] FAIL t1_ack: got %h want 0008", irq_ret_o); end
        tick();
        drive(1'b0, 1'b0, 16'h0008, 16'h0000);
        n_cmp++; if (irq_ret_o !== 16'h0000) begin n_err++; $display("[TB] FAIL t1_ack_once: got %h want 0000", irq_ret_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL t1_idle: got %b want 0", busy_o); end
        tick();
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0A40);
        n_cmp++; if (irq_cause_o !== 32'h8000_0016) begin n_err++; $display("[TB] FAIL t2_cause_a: got %h want 80000016", irq_cause_o); end
        tick();
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0A00);
        n_cmp++; if (irq_ret_o !== 16'h0040) begin n_err++; $display("[TB] FAIL t2_ack_a: got %h want 0040", irq_ret_o); end
        tick();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0A00);
        n_cmp++; if (irq_cause_o !== 32'h8000_0019) begin n_err++; $display("[TB] FAIL t2_cause_b: got %h want 80000019", irq_cause_o); end
        tick();
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        n_cmp++; if (irq_ret_o !== 16'h0200) begin n_err++; $display("[TB] FAIL t2_ack_b: got %h want 0200", irq_ret_o); end
        tick();
    endtask

    task automatic test_masking();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, 16'h0001, 16'hFFFE);
            n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("[TB] FAIL t3_masked[%0d]: got %b want 0", c, irq_o); end
            tick();
        end
        drive(1'b0, 1'b0, 16'h0002, 16'hFFFE);
        n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("[TB] FAIL t3_irq: got %b want 1", irq_o); end
        n_cmp++; if (irq_cause_o !== 32'h8000_0011) begin n_err++; $display("[TB] FAIL t3_cause: got %h want 80000011", irq_cause_o); end
        tick();
        drive(1'b0, 1'b1, 16'h0002, 16'h0000);
        tick();
    endtask

    task automatic test_exception_precedence();
        drive(1'b1, 1'b0, 16'hFFFF, 16'h0001);
        n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("[TB] FAIL t4_irq_blocked: got %b want 0", irq_o); end
        tick();
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0001);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("[TB] FAIL t4_busy: got %b want 1", busy_o); end
        n_cmp++; if (irq_ret_o !== 16'h0000) begin n_err++; $display("[TB] FAIL t4_no_ack: got %h want 0000", irq_ret_o); end
        tick();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0001);
        n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("[TB] FAIL t4_irq: got %b want 1", irq_o); end
        n_cmp++; if (irq_cause_o !== 32'h8000_0010) begin n_err++; $display("[TB] FAIL t4_cause: got %h want 80000010", irq_cause_o); end
        tick();
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        n_cmp++; if (irq_ret_o !== 16'h0001) begin n_err++; $display("[TB] FAIL t4_ack: got %h want 0001", irq_ret_o); end
        tick();
    endtask

    task automatic test_exc_in_irq();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0020);
        n_cmp++; if (irq_cause_o !== 32'h8000_0015) begin n_err++; $display("[TB] FAIL t5_cause: got %h want 80000015", irq_cause_o); end
        tick();
        drive(1'b1, 1'b1, 16'h0000, 16'h0001);
        n_cmp++; if (irq_ret_o !== 16'h0000) begin n_err++; $display("[TB] FAIL t5_exc_wins: got %h want 0000", irq_ret_o); end
        tick();
        drive(1'b0, 1'b1, 16'h0000, 16'h0001);
        n_cmp++; if (irq_ret_o !== 16'h0000) begin n_err++; $display("[TB] FAIL t5_exc_ret: got %h want 0000", irq_ret_o); end
        tick();
        drive(1'b0, 1'b1, 16'h0000, 16'h0001);
        n_cmp++; if (irq_ret_o !== 16'h0020) begin n_err++; $display("[TB] FAIL t5_ack: got %h want 0020", irq_ret_o); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL t5_idle: got %b want 0", busy_o); end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0010);
        tick();
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0010);
        n_cmp++; if (irq_ret_o !== 16'h0010) begin n_err++; $display("[TB] FAIL t6_pre_ack: got %h want 0010", irq_ret_o); end
        rst_i = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL t6_busy: got %b want 0", busy_o); end
        n_cmp++; if (irq_ret_o !== 16'h0000) begin n_err++; $display("[TB] FAIL t6_no_ack: got %h want 0000", irq_ret_o); end
        tick();
        drive(1'b0, 1'b0, '0, '0);
        rst_i = 1'b0;
        tick();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL t6_after: got %b want 0", busy_o); end
    endtask

    task automatic test_random();
        logic         e_irq, e_busy;
        logic [31:0]  e_cause;
        logic [N-1:0] e_ret;
        logic [N-1:0] mie, req;
        for (int c = 0; c < 1000; c++) begin
            mie = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
            req = N'($urandom & $urandom & $urandom);
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), mie, req);
            model_outputs(e_irq, e_cause, e_ret, e_busy);
            n_cmp++; if (irq_o !== e_irq) begin n_err++; $display("[TB] FAIL rnd_irq[%0d]: got %b want %b", c, irq_o, e_irq); end
            n_cmp++; if (irq_cause_o !== e_cause) begin n_err++; $display("[TB] FAIL rnd_cause[%0d]: got %h want %h", c, irq_cause_o, e_cause); end
            n_cmp++; if (irq_ret_o !== e_ret) begin n_err++; $display("[TB] FAIL rnd_ret[%0d]: got %h want %h", c, irq_ret_o, e_ret); end
            n_cmp++; if (busy_o !== e_busy) begin n_err++; $display("[TB] FAIL rnd_busy[%0d]: got %b want %b", c, busy_o, e_busy); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_exception_precedence();
        test_exc_in_irq();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
